// File: rtl/pe_relay_tile.sv
// pe_relay_tile: four-direction pass-through relay for empty PE-array grid slots.
// Each direction is an independent elastic FIFO channel (valid/ready) so
// back-pressure crosses the tile without loss. ap_start gates acceptance only;
// buffered words always drain.
// Optional build macro: PE_RELAY_STATS_EN adds stats_clr / stat_xfer_cnt and
// per-channel saturating output-transfer counters.

module pe_relay_chan #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             accept_en,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [PW:0]      count_r;
   logic             push_s;
   logic             pop_s;

   // Handshake decode; ready depends only on registered count and the accept enable.
   always_comb begin
      in_ready  = accept_en && (count_r != CNT_FULL);
      out_valid = (count_r != CNT_ZERO);
      out_data  = mem_r[rd_ptr_r];
      push_s    = in_valid && accept_en && (count_r != CNT_FULL);
      pop_s     = out_ready && (count_r != CNT_ZERO);
   end

   // Storage write; reset clears every entry so an empty channel presents zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

module pe_relay_tile #(
   parameter int EAST_WIDTH  = 130,
   parameter int WEST_WIDTH  = 131,
   parameter int NORTH_WIDTH = 294,
   parameter int SOUTH_WIDTH = 424,
   parameter int FIFO_DEPTH  = 2
`ifdef PE_RELAY_STATS_EN
   ,
   parameter int CNT_WIDTH   = 16
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ap_start,
   input  logic [EAST_WIDTH-1:0]  in_from_east,
   input  logic                   in_from_east_valid,
   output logic                   in_from_east_ready,
   output logic [EAST_WIDTH-1:0]  out_to_east,
   output logic                   out_to_east_valid,
   input  logic                   out_to_east_ready,
   input  logic [WEST_WIDTH-1:0]  in_from_west,
   input  logic                   in_from_west_valid,
   output logic                   in_from_west_ready,
   output logic [WEST_WIDTH-1:0]  out_to_west,
   output logic                   out_to_west_valid,
   input  logic                   out_to_west_ready,
   input  logic [NORTH_WIDTH-1:0] in_from_north,
   input  logic                   in_from_north_valid,
   output logic                   in_from_north_ready,
   output logic [NORTH_WIDTH-1:0] out_to_north,
   output logic                   out_to_north_valid,
   input  logic                   out_to_north_ready,
   input  logic [SOUTH_WIDTH-1:0] in_from_south,
   input  logic                   in_from_south_valid,
   output logic                   in_from_south_ready,
   output logic [SOUTH_WIDTH-1:0] out_to_south,
   output logic                   out_to_south_valid,
   input  logic                   out_to_south_ready
`ifdef PE_RELAY_STATS_EN
   ,
   input  logic                   stats_clr,
   output logic [4*CNT_WIDTH-1:0] stat_xfer_cnt
`endif
);
   logic run_r;
   logic accept_en_s;

   // Holds ready low while reset is asserted and until the first edge after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_r <= 1'b0;
      end else begin
         run_r <= 1'b1;
      end
   end

   assign accept_en_s = run_r & ap_start;

   pe_relay_chan #(.WIDTH(EAST_WIDTH), .DEPTH(FIFO_DEPTH)) u_east (
      .clk(clk), .reset(reset), .accept_en(accept_en_s),
      .in_data(in_from_east), .in_valid(in_from_east_valid), .in_ready(in_from_east_ready),
      .out_data(out_to_east), .out_valid(out_to_east_valid), .out_ready(out_to_east_ready)
   );

   pe_relay_chan #(.WIDTH(WEST_WIDTH), .DEPTH(FIFO_DEPTH)) u_west (
      .clk(clk), .reset(reset), .accept_en(accept_en_s),
      .in_data(in_from_west), .in_valid(in_from_west_valid), .in_ready(in_from_west_ready),
      .out_data(out_to_west), .out_valid(out_to_west_valid), .out_ready(out_to_west_ready)
   );

   pe_relay_chan #(.WIDTH(NORTH_WIDTH), .DEPTH(FIFO_DEPTH)) u_north (
      .clk(clk), .reset(reset), .accept_en(accept_en_s),
      .in_data(in_from_north), .in_valid(in_from_north_valid), .in_ready(in_from_north_ready),
      .out_data(out_to_north), .out_valid(out_to_north_valid), .out_ready(out_to_north_ready)
   );

   pe_relay_chan #(.WIDTH(SOUTH_WIDTH), .DEPTH(FIFO_DEPTH)) u_south (
      .clk(clk), .reset(reset), .accept_en(accept_en_s),
      .in_data(in_from_south), .in_valid(in_from_south_valid), .in_ready(in_from_south_ready),
      .out_data(out_to_south), .out_valid(out_to_south_valid), .out_ready(out_to_south_ready)
   );

`ifdef PE_RELAY_STATS_EN
   localparam logic [CNT_WIDTH-1:0] XFER_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] XFER_ONE = CNT_WIDTH'(1);

   logic [3:0]           pop_s;
   logic [CNT_WIDTH-1:0] xfer_cnt_r [4];

   assign pop_s = {out_to_south_valid & out_to_south_ready,
                   out_to_north_valid & out_to_north_ready,
                   out_to_west_valid  & out_to_west_ready,
                   out_to_east_valid  & out_to_east_ready};

   // Saturating per-channel output-transfer counters; clear wins over increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < 4; c++) begin
            xfer_cnt_r[c] <= {CNT_WIDTH{1'b0}};
         end
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (stats_clr) begin
               xfer_cnt_r[c] <= {CNT_WIDTH{1'b0}};
            end else if (pop_s[c] && (xfer_cnt_r[c] != XFER_MAX)) begin
               xfer_cnt_r[c] <= xfer_cnt_r[c] + XFER_ONE;
            end
         end
      end
   end

   assign stat_xfer_cnt = {xfer_cnt_r[3], xfer_cnt_r[2], xfer_cnt_r[1], xfer_cnt_r[0]};
`endif
endmodule

// File: tb/tb_pe_relay_tile.sv
// Self-checking bench for pe_relay_tile: per-channel scoreboards fed on accepted
// input handshakes and checked on output handshakes, plus directed timing checks.
`timescale 1ns/1ps
module tb_pe_relay_tile;
   localparam int EW = 130;
   localparam int WW = 131;
   localparam int NW = 294;
   localparam int SW = 424;
   localparam int MW = 424;

   logic clk = 1'b0;
   logic reset;
   logic ap_start;
   logic [EW-1:0] in_from_east;  logic in_from_east_valid;  logic in_from_east_ready;
   logic [EW-1:0] out_to_east;   logic out_to_east_valid;   logic out_to_east_ready;
   logic [WW-1:0] in_from_west;  logic in_from_west_valid;  logic in_from_west_ready;
   logic [WW-1:0] out_to_west;   logic out_to_west_valid;   logic out_to_west_ready;
   logic [NW-1:0] in_from_north; logic in_from_north_valid; logic in_from_north_ready;
   logic [NW-1:0] out_to_north;  logic out_to_north_valid;  logic out_to_north_ready;
   logic [SW-1:0] in_from_south; logic in_from_south_valid; logic in_from_south_ready;
   logic [SW-1:0] out_to_south;  logic out_to_south_valid;  logic out_to_south_ready;
`ifdef PE_RELAY_STATS_EN
   logic        stats_clr;
   logic [15:0] stat_xfer_cnt;
`endif

   int tests_run = 0;
   int fails = 0;
   int acc_cnt [4];
   int rx_cnt [4];
   logic [MW-1:0] sb_q [4][$];

   always #5 clk = ~clk;

   pe_relay_tile #(
`ifdef PE_RELAY_STATS_EN
      .CNT_WIDTH(4),
`endif
      .EAST_WIDTH(EW), .WEST_WIDTH(WW), .NORTH_WIDTH(NW), .SOUTH_WIDTH(SW), .FIFO_DEPTH(2)
   ) dut (
      .clk(clk), .reset(reset), .ap_start(ap_start),
      .in_from_east(in_from_east), .in_from_east_valid(in_from_east_valid), .in_from_east_ready(in_from_east_ready),
      .out_to_east(out_to_east), .out_to_east_valid(out_to_east_valid), .out_to_east_ready(out_to_east_ready),
      .in_from_west(in_from_west), .in_from_west_valid(in_from_west_valid), .in_from_west_ready(in_from_west_ready),
      .out_to_west(out_to_west), .out_to_west_valid(out_to_west_valid), .out_to_west_ready(out_to_west_ready),
      .in_from_north(in_from_north), .in_from_north_valid(in_from_north_valid), .in_from_north_ready(in_from_north_ready),
      .out_to_north(out_to_north), .out_to_north_valid(out_to_north_valid), .out_to_north_ready(out_to_north_ready),
      .in_from_south(in_from_south), .in_from_south_valid(in_from_south_valid), .in_from_south_ready(in_from_south_ready),
      .out_to_south(out_to_south), .out_to_south_valid(out_to_south_valid), .out_to_south_ready(out_to_south_ready)
`ifdef PE_RELAY_STATS_EN
      , .stats_clr(stats_clr), .stat_xfer_cnt(stat_xfer_cnt)
`endif
   );

   // Uniform per-channel views, index 0..3 = east, west, north, south.
   logic [MW-1:0] in_d [4];
   logic [MW-1:0] out_d [4];
   logic [3:0] in_v, in_r, out_v, out_r;
   assign in_d[0] = MW'(in_from_east);   assign out_d[0] = MW'(out_to_east);
   assign in_d[1] = MW'(in_from_west);   assign out_d[1] = MW'(out_to_west);
   assign in_d[2] = MW'(in_from_north);  assign out_d[2] = MW'(out_to_north);
   assign in_d[3] = in_from_south;       assign out_d[3] = out_to_south;
   assign in_v  = {in_from_south_valid, in_from_north_valid, in_from_west_valid, in_from_east_valid};
   assign in_r  = {in_from_south_ready, in_from_north_ready, in_from_west_ready, in_from_east_ready};
   assign out_v = {out_to_south_valid, out_to_north_valid, out_to_west_valid, out_to_east_valid};
   assign out_r = {out_to_south_ready, out_to_north_ready, out_to_west_ready, out_to_east_ready};

   // Scoreboard monitor: sample handshakes mid-cycle, before the edge that commits them.
   always @(negedge clk) begin
      if (reset) begin
         for (int c = 0; c < 4; c++) sb_q[c].delete();
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (in_v[c] && in_r[c]) begin
               sb_q[c].push_back(in_d[c]);
               acc_cnt[c]++;
            end
            if (out_v[c] && out_r[c]) begin
               logic [MW-1:0] exp_d;
               tests_run++;
               rx_cnt[c]++;
               if (sb_q[c].size() == 0) begin
                  fails++;
                  $display("FAIL sb_unexpected ch%0d: got %h, required no output", c, out_d[c]);
               end else begin
                  exp_d = sb_q[c].pop_front();
                  if (out_d[c] !== exp_d) begin
                     fails++;
                     $display("FAIL sb_data ch%0d: got %h, required %h", c, out_d[c], exp_d);
                  end
               end
            end
         end
      end
   end

   function automatic logic [MW-1:0] rnd_word();
      logic [MW-1:0] r;
      for (int k = 0; k < 13; k++) r[k*32 +: 32] = $urandom;
      r[423:416] = 8'($urandom);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [MW-1:0] got, input logic [MW-1:0] req);
      tests_run++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; ap_start = 1'b1;
      in_from_east_valid = 1'b0; in_from_west_valid = 1'b0;
      in_from_north_valid = 1'b0; in_from_south_valid = 1'b0;
      in_from_east = '0; in_from_west = '0; in_from_north = '0; in_from_south = '0;
      out_to_east_ready = 1'b1; out_to_west_ready = 1'b1;
      out_to_north_ready = 1'b1; out_to_south_ready = 1'b1;
`ifdef PE_RELAY_STATS_EN
      stats_clr = 1'b0;
`endif
      tick(); tick();
      for (int c = 0; c < 4; c++) begin
         tests_run++;
         if (out_v[c] !== 1'b0 || in_r[c] !== 1'b0 || out_d[c] !== {MW{1'b0}}) begin
            fails++;
            $display("FAIL reset_state ch%0d: got valid=%b ready=%b data=%h, required 0/0/0", c, out_v[c], in_r[c], out_d[c]);
         end
      end
      reset = 1'b0;
      #1;
      chk("ready_before_first_edge", MW'(in_r), MW'(4'b0000));
      tick();
      chk("ready_after_first_edge", MW'(in_r), MW'(4'b1111));
   endtask

   task automatic test_single_east();
      in_from_east = EW'(1); in_from_east_valid = 1'b1;
      tick();
      in_from_east_valid = 1'b0;
      chk("east_latency_valid", MW'(out_to_east_valid), MW'(1'b1));
      chk("east_latency_data", MW'(out_to_east), MW'(1));
      tick();
      chk("east_valid_drops", MW'(out_to_east_valid), MW'(1'b0));
   endtask

   task automatic test_north_backpressure();
      out_to_north_ready = 1'b0;
      in_from_north = NW'(1); in_from_north_valid = 1'b1;
      tick();
      in_from_north = NW'(2);
      chk("north_ready_one_entry", MW'(in_from_north_ready), MW'(1'b1));
      tick();
      in_from_north = NW'(3);
      chk("north_ready_full", MW'(in_from_north_ready), MW'(1'b0));
      tick();
      chk("north_ready_stalled", MW'(in_from_north_ready), MW'(1'b0));
      chk("north_head_hold", MW'(out_to_north), MW'(1));
      out_to_north_ready = 1'b1;
      #1;
      chk("north_ready_not_comb", MW'(in_from_north_ready), MW'(1'b0));
      tick();
      chk("north_ready_after_pop", MW'(in_from_north_ready), MW'(1'b1));
      tick();
      in_from_north_valid = 1'b0;
      tick(); tick();
      chk("north_drained", MW'(out_to_north_valid), MW'(1'b0));
      chk("north_accepted_3", MW'(acc_cnt[2]), MW'(3));
   endtask

   task automatic test_back_to_back();
      logic [MW-1:0] w;
      int a0 [4];
      int r0 [4];
      for (int c = 0; c < 4; c++) begin a0[c] = acc_cnt[c]; r0[c] = rx_cnt[c]; end
      in_from_east_valid = 1'b1; in_from_west_valid = 1'b1;
      in_from_north_valid = 1'b1; in_from_south_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         w = rnd_word(); in_from_east  = w[EW-1:0];
         w = rnd_word(); in_from_west  = w[WW-1:0];
         w = rnd_word(); in_from_north = w[NW-1:0];
         w = rnd_word(); in_from_south = w;
         tick();
      end
      in_from_east_valid = 1'b0; in_from_west_valid = 1'b0;
      in_from_north_valid = 1'b0; in_from_south_valid = 1'b0;
      tick(); tick(); tick();
      for (int c = 0; c < 4; c++) begin
         tests_run++;
         if ((acc_cnt[c] - a0[c]) != 100 || (rx_cnt[c] - r0[c]) != 100) begin
            fails++;
            $display("FAIL b2b_count ch%0d: got acc=%0d rx=%0d, required 100/100", c, acc_cnt[c] - a0[c], rx_cnt[c] - r0[c]);
         end
      end
   endtask

   task automatic test_south_drain();
      out_to_south_ready = 1'b0;
      in_from_south_valid = 1'b1;
      in_from_south = {SW{1'b1}};
      tick();
      in_from_south = {{(SW-8){1'b0}}, 8'hA5};
      tick();
      ap_start = 1'b0;
      in_from_south = {SW{1'b0}};
      out_to_south_ready = 1'b1;
      #1;
      chk("south_ready_apstart_low", MW'(in_from_south_ready), MW'(1'b0));
      tick();
      chk("south_drain1_valid", MW'(out_to_south_valid), MW'(1'b1));
      chk("south_drain1_ready", MW'(in_from_south_ready), MW'(1'b0));
      tick();
      chk("south_drained", MW'(out_to_south_valid), MW'(1'b0));
      chk("south_drain2_ready", MW'(in_from_south_ready), MW'(1'b0));
      in_from_south_valid = 1'b0;
      ap_start = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      out_to_west_ready = 1'b0;
      in_from_west_valid = 1'b1;
      in_from_west = {WW{1'b1}};
      tick();
      in_from_west = {{(WW-4){1'b0}}, 4'h9};
      tick();
      in_from_west_valid = 1'b0;
      chk("west_full_before_reset", MW'(out_to_west_valid), MW'(1'b1));
      #2 reset = 1'b1;
      #1;
      chk("west_reset_valid", MW'(out_to_west_valid), MW'(1'b0));
      chk("west_reset_data", MW'(out_to_west), MW'(0));
      chk("west_reset_ready", MW'(in_from_west_ready), MW'(1'b0));
      tick();
      reset = 1'b0;
      tick();
      out_to_west_ready = 1'b1;
      #1;
      chk("west_empty_after_reset", MW'(out_to_west_valid), MW'(1'b0));
      tick();
      chk("west_still_empty", MW'(out_to_west_valid), MW'(1'b0));
   endtask

`ifdef PE_RELAY_STATS_EN
   task automatic test_stats();
      stats_clr = 1'b1; tick(); stats_clr = 1'b0;
      chk("stats_clr_initial", MW'(stat_xfer_cnt[3:0]), MW'(0));
      in_from_east_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin in_from_east = EW'(i + 16); tick(); end
      in_from_east_valid = 1'b0;
      tick(); tick();
      chk("stats_saturate", MW'(stat_xfer_cnt[3:0]), MW'(15));
      stats_clr = 1'b1; tick(); stats_clr = 1'b0;
      chk("stats_clr_pulse", MW'(stat_xfer_cnt[3:0]), MW'(0));
      in_from_east = EW'(7); in_from_east_valid = 1'b1;
      tick();
      in_from_east_valid = 1'b0;
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      chk("stats_clr_over_pop", MW'(stat_xfer_cnt[3:0]), MW'(0));
   endtask
`endif

   task automatic test_final_empty();
      for (int c = 0; c < 4; c++) begin
         tests_run++;
         if (sb_q[c].size() != 0) begin
            fails++;
            $display("FAIL sb_leftover ch%0d: got %0d pending, required 0", c, sb_q[c].size());
         end
      end
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int c = 0; c < 4; c++) begin acc_cnt[c] = 0; rx_cnt[c] = 0; end
      test_reset();
      test_single_east();
      test_north_backpressure();
      test_back_to_back();
      test_south_drain();
      test_reset_mid();
`ifdef PE_RELAY_STATS_EN
      test_stats();
`endif
      tick(); tick();
      test_final_empty();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
